mebx_ext_in_ctrl: RTL

Avalon-MM slave controller for a single external input line, such as the EXT sync/trigger pin. It synchronises and debounces the pin with a programmable filter, captures rising and falling edges, and raises a maskable level interrupt. It sits between the board pin and the Nios II data bus, in place of a raw PIO input.

---
 rtl/mebx_ext_in_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mebx_ext_in_ctrl.sv
// ---------------------------------------------------------------------------
// mebx_ext_in_ctrl
//
// Avalon-MM slave for one external input pin (EXT sync/trigger). The pin is
// synchronised, debounced with a programmable reload, and its rising/falling
// edges are captured into write-1-to-clear bits that drive a maskable,
// level-sensitive interrupt.
//
// Debounce FSM:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_STABLE | sync_in matches the debounced level; waiting for a change
//   ST_COUNT  | sync_in differs; counting down the filter before committing
//
// Register map (readdata is registered from address every clock):
//   0 : bit0 debounced level (RO)
//   1 : bit0 irq mask (RW)
//   2 : bit0 rising captured, bit1 falling captured (W1C)
//   3 : [DEBOUNCE_W-1:0] debounce reload (RW), used on the next counter load
//   4 : timestamp of the last commit (only with EXT_IN_TIMESTAMP_EN), else 0
//   5-7 : read 0, writes ignored
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    Avalon word address
//   write      Avalon write strobe
//   writedata  Avalon write data
//   readdata   Avalon read data, registered (1-cycle latency)
//   in_port    asynchronous external input
//   irq        interrupt request, active high, level
//
// Optional feature macro: EXT_IN_TIMESTAMP_EN adds a free-running 32-bit
// counter and a timestamp register latched on every debounce commit.
// ---------------------------------------------------------------------------
module mebx_ext_in_ctrl #(
    parameter int unsigned           SYNC_STAGES  = 2,
    parameter int unsigned           DEBOUNCE_W   = 16,
    parameter logic [DEBOUNCE_W-1:0] DEBOUNCE_DEF = 16'd1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        in_port,
    output logic        irq
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    sync_in;
    logic                    level_q, level_d;
    logic [DEBOUNCE_W-1:0]   cnt_q, cnt_d;
    logic [1:0]              edge_set;

    logic                    mask_q;
    logic [1:0]              edge_cap_q, edge_cap_d;
    logic [1:0]              edge_clr;
    logic [DEBOUNCE_W-1:0]   reload_q;
    logic [31:0]             ts_val;
    logic [31:0]             rd_d;

    logic                    wr_mask, wr_edge, wr_reload;
    logic                    unused_wdata;

    assign unused_wdata = ^writedata;

    // ---------------------------------------------------------------
    // Input synchroniser
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    // ---------------------------------------------------------------
    // Debounce FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        edge_set = 2'b00;
        case (state_q)
            ST_STABLE: begin
                if (sync_in != level_q) begin
                    cnt_d   = reload_q;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (sync_in == level_q) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == '0) begin
                    level_d  = sync_in;
                    edge_set = sync_in ? 2'b01 : 2'b10;
                    state_d  = ST_STABLE;
                end else begin
                    cnt_d = cnt_q - DEBOUNCE_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------
    assign wr_mask   = write && (address == 3'd1);
    assign wr_edge   = write && (address == 3'd2);
    assign wr_reload = write && (address == 3'd3);
    assign edge_clr  = wr_edge ? writedata[1:0] : 2'b00;

    // A commit in the same cycle as a clear of that bit keeps the bit set.
    assign edge_cap_d = (edge_cap_q & ~edge_clr) | edge_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= 1'b0;
            edge_cap_q <= 2'b00;
            reload_q   <= DEBOUNCE_DEF;
        end else begin
            edge_cap_q <= edge_cap_d;
            if (wr_mask) begin
                mask_q <= writedata[0];
            end
            if (wr_reload) begin
                reload_q <= writedata[DEBOUNCE_W-1:0];
            end
        end
    end

    // ---------------------------------------------------------------
    // Optional commit timestamp
    // ---------------------------------------------------------------
`ifdef EXT_IN_TIMESTAMP_EN
    logic [31:0] ts_cnt_q;
    logic [31:0] ts_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 32'd1;
            if (edge_set != 2'b00) begin
                ts_q <= ts_cnt_q;
            end
        end
    end

    assign ts_val = ts_q;
`else
    assign ts_val = '0;
`endif

    // ---------------------------------------------------------------
    // Read mux and interrupt
    // ---------------------------------------------------------------
    always_comb begin
        rd_d = '0;
        case (address)
            3'd0:    rd_d = {31'd0, level_q};
            3'd1:    rd_d = {31'd0, mask_q};
            3'd2:    rd_d = {30'd0, edge_cap_q};
            3'd3:    rd_d = 32'(reload_q);
            3'd4:    rd_d = ts_val;
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_d;
            irq      <= |(edge_cap_q & {2{mask_q}});
        end
    end

endmodule
